// File: rtl/sd_spi_ctrl.sv
// sd_spi_ctrl: CPU I/O front end for the SD card SPI byte engine.
// Single-byte transfers plus hardware burst reads (0xFF out) into an rx FIFO.
module sd_spi_ctrl #(
    parameter logic [11:0] BASE    = 12'h0B8,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [19:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iIoRd,
    input  logic        iIoWr,
    output logic        oSel,
    output logic [7:0]  oData,
    output logic        oSpiSend,
    output logic [7:0]  oSpiData,
    input  logic [7:0]  iSpiData,
    input  logic        iSpiAvail,
    output logic        oSdCs,
    output logic        oBusy
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t          state, next_state;
    logic            burst, stall, abort_pend, ovr, cs;
    logic [15:0]     count;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, occ, occ_after;
    logic            empty, full, full_after, push_req, push, pop;
    logic            start_single, start_burst, dec, abort_now, ovr_set;
    logic [4:0]      hit;
    logic            wr0, wr1, wr3, wr4, rd0, rd2, rd_any;
    logic [7:0]      status;
    logic            unused_addr;

    assign unused_addr = ^iAddr[19:12];

    // Register decode within the 5-byte window
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            hit[k] = (iAddr[11:0] == BASE + 12'(k));
        end
    end

    assign wr0    = iIoWr & hit[0];
    assign wr1    = iIoWr & hit[1];
    assign wr3    = iIoWr & hit[3];
    assign wr4    = iIoWr & hit[4];
    assign rd0    = iIoRd & hit[0];
    assign rd2    = iIoRd & hit[2];
    assign rd_any = iIoRd & (|hit);

    // FIFO occupancy and push/pop qualification
    assign occ        = wr_ptr - rd_ptr;
    assign empty      = (occ == '0);
    assign full       = (occ == PW'(DEPTH));
    assign pop        = rd0 & ~empty;
    assign push_req   = (state == WAIT) & ~stall & iSpiAvail;
    assign push       = push_req & (~full | pop);
    assign occ_after  = occ + PW'(push) - PW'(pop);
    assign full_after = (occ_after == PW'(DEPTH));
    assign abort_now  = abort_pend | (wr1 & iData[7]);
    assign status     = {4'b0000, ovr, full, ~empty, (state != IDLE)};
    assign ovr_set    = ((wr0 | wr4) & (state != IDLE)) | (push_req & ~push);

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state and transfer control
    always_comb begin
        next_state   = state;
        start_single = 1'b0;
        start_burst  = 1'b0;
        dec          = 1'b0;
        case (state)
            IDLE: begin
                if (wr0) begin
                    next_state   = SEND;
                    start_single = 1'b1;
                end else if (wr4 && ({iData, count[7:0]} != 16'h0000)) begin
                    next_state  = SEND;
                    start_burst = 1'b1;
                end
            end
            SEND: next_state = WAIT;
            WAIT: begin
                if (stall) begin
                    if (abort_now)       next_state = IDLE;
                    else if (!full_after) next_state = SEND;
                end else if (iSpiAvail) begin
                    if (!burst) begin
                        next_state = IDLE;
                    end else begin
                        dec = 1'b1;
                        if (count == 16'd1 || abort_now) next_state = IDLE;
                        else if (!full_after)            next_state = SEND;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FIFO storage (no reset needed: pointers define validity)
    always_ff @(posedge iClk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= iSpiData;
    end

    // FIFO pointers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Control/status registers and SPI-side outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cs         <= 1'b1;
            ovr        <= 1'b0;
            burst      <= 1'b0;
            stall      <= 1'b0;
            abort_pend <= 1'b0;
            count      <= 16'h0000;
            oSpiData   <= 8'hFF;
            oSpiSend   <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            if (wr1) cs <= iData[0];
            if (ovr_set)  ovr <= 1'b1;
            else if (rd2) ovr <= 1'b0;
            if (start_single) begin
                burst    <= 1'b0;
                oSpiData <= iData;
            end else if (start_burst) begin
                burst    <= 1'b1;
                oSpiData <= 8'hFF;
            end
            if (state == IDLE && wr3) count[7:0]  <= iData;
            if (state == IDLE && wr4) count[15:8] <= iData;
            if (dec) count <= count - 16'd1;
            stall <= (next_state == WAIT) & (stall | push_req);
            if (next_state == IDLE)                 abort_pend <= 1'b0;
            else if (wr1 && iData[7] && state != IDLE) abort_pend <= 1'b1;
            oSpiSend <= (next_state == SEND);
            oBusy    <= (next_state != IDLE);
        end
    end

    // CPU read path
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oSel  <= 1'b0;
            oData <= 8'hFF;
        end else begin
            oSel <= rd_any;
            if (rd0)         oData <= empty ? 8'hFF : mem[rd_ptr[FIFO_AW-1:0]];
            else if (rd2)    oData <= status;
            else if (rd_any) oData <= 8'hFF;
        end
    end

    assign oSdCs = cs;

endmodule
